// File: rtl/cnn_stream_loader.sv
// Packs a header/matrix word stream into bus writes and job start for cnn_hw_accelerator.
// Define CNN_LOADER_CHECK_EN to enable dimension/length checking, errorOut and the DRAIN state.
module cnn_stream_loader #(
  parameter int          BUS_ADDR_WIDTH = 32,
  parameter int          BUS_DATA_WIDTH = 64,
  parameter int          DATA_WIDTH     = 32,
  parameter int          MAX_SIZE       = 4096,
  parameter int unsigned DATA_ADDR      = 0,
  parameter int unsigned FILT_ADDR      = 16384,
  localparam int         DIM_WIDTH      = $clog2(MAX_SIZE) + 1
) (
  input  logic                        clkIn,
  input  logic                        rstIn,
  input  logic [DATA_WIDTH-1:0]       dataIn,
  input  logic                        validIn,
  input  logic                        lastIn,
  output logic                        readyOut,
  output logic [DIM_WIDTH-1:0]        dataRowsOut,
  output logic [DIM_WIDTH-1:0]        dataColsOut,
  output logic [DIM_WIDTH-1:0]        filtRowsOut,
  output logic [DIM_WIDTH-1:0]        filtColsOut,
  output logic [BUS_ADDR_WIDTH-1:0]   addrOut,
  output logic [BUS_DATA_WIDTH/8-1:0] wrEnOut,
  output logic [BUS_DATA_WIDTH-1:0]   wrDataOut,
  output logic                        startOut,
  output logic                        busyOut,
  output logic                        errorOut
);
  localparam int NUM_WORDS  = BUS_DATA_WIDTH / DATA_WIDTH;
  localparam int LANE_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int LANE_BYTES = DATA_WIDTH / 8;
  localparam int BUS_BYTES  = BUS_DATA_WIDTH / 8;
  localparam int CNT_W      = DIM_WIDTH + 1;

  typedef enum logic [3:0] {
    IDLE, DCOLS, DROWS, DLOAD, FCOLS, FROWS, FLOAD, START
`ifdef CNN_LOADER_CHECK_EN
    , DRAIN
`endif
  } state_t;

  state_t                    state, nextState;
  logic                      accept, loading, beatNow, endMatrix;
  logic [LANE_W-1:0]         laneIdx;
  logic [CNT_W-1:0]          beatCnt;
  logic [BUS_DATA_WIDTH-1:0] packBuf, beatData;
  logic [BUS_BYTES-1:0]      beatEn;
  logic [BUS_ADDR_WIDTH-1:0] beatAddr;
  logic [DIM_WIDTH-1:0]      dimIn;

  assign dimIn   = dataIn[DIM_WIDTH-1:0];
  assign accept  = validIn && readyOut;
  assign loading = (state == DLOAD) || (state == FLOAD);
  assign busyOut = (state != IDLE);

  always_comb begin
    case (state)
      DCOLS, DROWS, DLOAD, FCOLS, FROWS, FLOAD: readyOut = 1'b1;
`ifdef CNN_LOADER_CHECK_EN
      DRAIN:                                   readyOut = 1'b1;
`endif
      default:                                 readyOut = 1'b0;
    endcase
  end

`ifdef CNN_LOADER_CHECK_EN
  logic [CNT_W-1:0]       elemCnt, prodReg;
  logic [2*DIM_WIDTH-1:0] prodFull;
  logic [DIM_WIDTH-1:0]   colsCur;
  logic                   countDone, headerBad, loadErr, setErr;

  assign colsCur   = (state == FROWS) ? filtColsOut : dataColsOut;
  assign prodFull  = (2*DIM_WIDTH)'(dimIn) * (2*DIM_WIDTH)'(colsCur);
  assign headerBad = (dimIn == '0) || (colsCur == '0) ||
                     (prodFull > (2*DIM_WIDTH)'(MAX_SIZE));
  assign countDone = (elemCnt + CNT_W'(1)) == prodReg;
  assign endMatrix = lastIn || countDone;
  // A matrix is well formed only when lastIn and the element count agree
  assign loadErr   = (lastIn != countDone);
`else
  assign endMatrix = lastIn;
`endif

  assign beatNow  = accept && loading && ((laneIdx == LANE_W'(NUM_WORDS - 1)) || endMatrix);
  assign beatAddr = BUS_ADDR_WIDTH'((state == FLOAD) ? FILT_ADDR : DATA_ADDR) +
                    BUS_ADDR_WIDTH'(beatCnt) * BUS_ADDR_WIDTH'(BUS_BYTES);

  always_comb begin
    beatData = packBuf;
    beatData[laneIdx*DATA_WIDTH +: DATA_WIDTH] = dataIn;
    for (int l = 0; l < NUM_WORDS; l++)
      beatEn[l*LANE_BYTES +: LANE_BYTES] = (LANE_W'(l) <= laneIdx) ? '1 : '0;
  end

  always_comb begin
    nextState = state;
`ifdef CNN_LOADER_CHECK_EN
    setErr = 1'b0;
`endif
    case (state)
      IDLE:  if (validIn) nextState = DCOLS;
      DCOLS: if (accept) nextState = DROWS;
      FCOLS: if (accept) nextState = FROWS;
      DROWS, FROWS: if (accept) begin
        nextState = (state == DROWS) ? DLOAD : FLOAD;
`ifdef CNN_LOADER_CHECK_EN
        if (headerBad) begin
          setErr    = 1'b1;
          nextState = lastIn ? IDLE : DRAIN;
        end
`endif
      end
      DLOAD, FLOAD: if (accept && endMatrix) begin
        nextState = (state == DLOAD) ? FCOLS : START;
`ifdef CNN_LOADER_CHECK_EN
        if (loadErr) begin
          setErr    = 1'b1;
          nextState = lastIn ? IDLE : DRAIN;
        end
`endif
      end
      START: nextState = IDLE;
`ifdef CNN_LOADER_CHECK_EN
      DRAIN: if (accept && lastIn) nextState = IDLE;
`endif
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      dataRowsOut <= '0;
      dataColsOut <= '0;
      filtRowsOut <= '0;
      filtColsOut <= '0;
      addrOut     <= '0;
      wrEnOut     <= '0;
      wrDataOut   <= '0;
      startOut    <= 1'b0;
      laneIdx     <= '0;
      beatCnt     <= '0;
      packBuf     <= '0;
    end else begin
      wrEnOut   <= '0;
      wrDataOut <= '0;
      startOut  <= (state == START);
      if (accept) begin
        case (state)
          DCOLS, FCOLS: begin
            if (state == DCOLS) dataColsOut <= dimIn;
            else                filtColsOut <= dimIn;
            laneIdx <= '0;
            beatCnt <= '0;
            packBuf <= '0;
          end
          DROWS: dataRowsOut <= dimIn;
          FROWS: filtRowsOut <= dimIn;
          DLOAD, FLOAD: begin
            if (beatNow) begin
              wrEnOut   <= beatEn;
              wrDataOut <= beatData;
              addrOut   <= beatAddr;
              beatCnt   <= beatCnt + CNT_W'(1);
              laneIdx   <= '0;
              packBuf   <= '0;
            end else begin
              packBuf <= beatData;
              laneIdx <= laneIdx + LANE_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CNN_LOADER_CHECK_EN
  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      elemCnt  <= '0;
      prodReg  <= '0;
      errorOut <= 1'b0;
    end else begin
      if (accept && state == DCOLS) errorOut <= 1'b0;
      else if (setErr)              errorOut <= 1'b1;
      if (accept) begin
        case (state)
          DROWS, FROWS: begin
            prodReg <= prodFull[CNT_W-1:0];
            elemCnt <= '0;
          end
          DLOAD, FLOAD: elemCnt <= elemCnt + CNT_W'(1);
          default: ;
        endcase
      end
    end
  end
`else
  assign errorOut = 1'b0;
`endif

endmodule
